config_loader: RTL and testbench
================================

# config_loader

Sequencer that streams a configuration bitstream into a daisy-chain of logic elements over their serial programming port (`prog_in`, `prog_clk`, `prog_en`). It sits between a bitstream source (ROM reader, UART receiver) and the first element of the fabric chain. It accepts bytes over a valid/ready handshake, serialises them, generates `prog_clk`, and frames the load with `prog_en`. The falling edge of `prog_en` commits the shifted contents into every element's active control register.

## Interface
- `NUM_ELEMENTS`, default 4: logic elements in the chain.
- `LE_CFG_BITS`, default 19: configuration bits per element.
- `WORD_W`, default 8: width of input words.
- `clk` input 1: system clock; the only clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse to begin a load. Ignored while `busy`.
- `in_data` input WORD_W: bitstream word, MSB shifted first.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: controller accepts the word this cycle.
- `prog_in` output 1: serial data to the first element.
- `prog_clk` output 1: programming shift clock, registered.
- `prog_en` output 1: programming enable; its falling edge commits.
- `prog_out_last` input 1: `prog_out` of the last element in the chain.
- `busy` output 1: load in progress.
- `done` output 1: one-cycle pulse when the commit completes.

## Operation
- `TOTAL_BITS = NUM_ELEMENTS*LE_CFG_BITS`.
- `NUM_WORDS = ceil(TOTAL_BITS/WORD_W)`. Unused LSBs of the final word are discarded.
- Stream order: last element first. Within each element, control bit 18 is sent first, down to bit 0.
- State machine:
  - IDLE: on `start`, set `prog_en`=1, clear the bit counter, go to FETCH.
  - FETCH: `in_ready`=1. On `in_valid`, latch the word into the shift register, go to SHIFT_LO.
  - SHIFT_LO: drive `prog_in` = current MSB, `prog_clk`=0. Next state is SHIFT_HI.
  - SHIFT_HI: `prog_clk`=1; elements shift on this rising edge. Increment the bit counter and shift the word left.
    - Counter reaches `TOTAL_BITS`: go to COMMIT.
    - Word exhausted: go to FETCH.
    - Otherwise: go to SHIFT_LO.
  - COMMIT: `prog_clk`=0, `prog_en`=0 (commit edge). Go to DONE.
  - DONE: `done`=1 for one cycle, `busy` drops, return to IDLE.
- Source starvation: FETCH waits indefinitely with `prog_en`=1 and `prog_clk`=0. No timeout.
- `start` during `busy`: ignored.
- Bit counter width: `$clog2(TOTAL_BITS+1)`. The counter never wraps.
- Reset mid-load: all outputs go to their reset values. The resulting `prog_en` fall commits the partial chain contents. The fabric is then undefined until a full reload; no partial-load protection is provided.

## Timing
- Reset values:
  - `prog_en`=0, `prog_clk`=0, `prog_in`=0
  - `in_ready`=0, `busy`=0, `done`=0
  - state IDLE
- All outputs are registered except `in_ready`, which is decoded from state.
- `start` seen in cycle N: `prog_en`=1 and `busy`=1 from N+1. First `in_ready` in N+1.
- Each bit takes 2 `clk` cycles. `prog_in` is stable one full cycle before and during each `prog_clk` rise.
- Each word costs 1 FETCH cycle with immediate `in_valid`.
- Minimum load latency, `start` to `done`: `2*TOTAL_BITS + NUM_WORDS + 3` cycles. With defaults (76 bits, 10 words) this is 165 cycles.
- `prog_en` fall occurs one cycle after the final `prog_clk` rise. `done` asserts the cycle after that.

## Configuration
- `CONFIG_LOADER_READBACK_EN` defined: adds output `rb_data` [WORD_W] and output `rb_valid` [1].
  - On each SHIFT_LO cycle, sample `prog_out_last` into a readback shift register.
  - `rb_valid` pulses for one cycle when WORD_W bits have been collected.
  - In COMMIT, a final partial word is emitted with its LSBs zero-padded.
  - The previous configuration is therefore returned in the same order it was written.
  - No backpressure on readback.
- Undefined: the ports are absent and `prog_out_last` is unused.

## Structure
- Shared package `fabric_cfg_pkg` holds:
  - `LE_CFG_BITS` = 19
  - control-bit index constants (LUT 0–15, FF enable mux 16, feedback mux 17, output mux 18)
  - the loader state enum
- One sub-module, `cfg_word_serializer`: word load, MSB shift-out and the exhausted flag. It is reused by the readback deserializer path in mirrored form.

## Test plan
- Default parameters, 10 words streamed back-to-back with a known pattern: chain of 4 behavioural elements holds the exact 76 bits in order; `done` arrives 165 cycles after `start`.
- `in_valid` withheld 20 cycles before word 3: `prog_en` stays 1 and `prog_clk` stays 0 throughout the stall. Final contents unchanged; latency grows by exactly 20.
- Element 0 programmed with LUT = 16'h8000 and bits 18:16 = 0: after commit, `out`=1 only for `in`=4'hF.
- `rst` asserted after 30 bits: next cycle `prog_en`=0, `busy`=0, `done`=0. A following full load is correct.
- `start` pulsed again at cycle 50 of a load: ignored, and exactly one `done`.
- With `CONFIG_LOADER_READBACK_EN`, two consecutive loads A then B: the second load emits 10 `rb_valid` words equal to A, with the last word's 4 LSBs zero.

Source files
------------

// File: rtl/fabric_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fabric_cfg_pkg
// Description : Shared definitions for the fabric configuration path:
//               per-element configuration width, control-bit positions
//               inside one logic element, and the loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fabric_cfg_pkg;

    // Configuration bits held by one logic element.
    localparam int LE_CFG_BITS     = 19;

    // Control-bit positions inside one element's configuration word.
    localparam int CFG_LUT_LSB     = 0;   // LUT truth table, bits 15:0
    localparam int CFG_LUT_MSB     = 15;
    localparam int CFG_FF_EN_BIT   = 16;  // flip-flop enable mux
    localparam int CFG_FB_MUX_BIT  = 17;  // feedback mux
    localparam int CFG_OUT_MUX_BIT = 18;  // output mux, first bit streamed

    // Loader sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_COMMIT   = 3'd4,
        ST_DONE     = 3'd5
    } loader_state_t;

endpackage : fabric_cfg_pkg
`default_nettype wire

// File: rtl/cfg_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : cfg_word_serializer
// Description : One-word shift register with a bit counter. Loads a word,
//               shifts it left one bit per request (serial_i enters at the
//               LSB) and flags the last bit of the word. Used MSB-out on the
//               programming path and, fed from the chain tail, as the
//               readback deserializer.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, rst     : system clock, synchronous active-high reset
//   load_i       : load data_i and clear the bit counter (wins over shift)
//   data_i       : word to load
//   shift_i      : shift left by one, serial_i into bit 0, count + 1
//   serial_i     : bit entering at the LSB
//   word_o       : current register contents
//   next_msb_o   : bit that becomes the MSB after the next shift
//   count_o      : bits shifted since the last load
//   last_o       : the next shift completes the word
//
// WORD_W must be at least 2.
// ============================================================================
module cfg_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_i,
    input  logic [WORD_W-1:0]            data_i,
    input  logic                         shift_i,
    input  logic                         serial_i,
    output logic [WORD_W-1:0]            word_o,
    output logic                         next_msb_o,
    output logic [$clog2(WORD_W+1)-1:0]  count_o,
    output logic                         last_o
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            word_q <= data_i;
            cnt_q  <= '0;
        end else if (shift_i) begin
            word_q <= {word_q[WORD_W-2:0], serial_i};
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign word_o     = word_q;
    assign next_msb_o = word_q[WORD_W-2];
    assign count_o    = cnt_q;
    assign last_o     = (cnt_q == CNT_W'(WORD_W - 1));

endmodule : cfg_word_serializer
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module      : config_loader
// Description : Streams a configuration bitstream into a daisy chain of
//               logic elements. Accepts words over valid/ready, shifts them
//               out MSB first with a registered prog_clk (two clk cycles per
//               bit) and frames the load with prog_en, whose falling edge
//               commits the chain. The last element's bits are streamed
//               first, bit 18 down to bit 0.
// Revision    : 1.0 - initial release
//
// Build option
//   CONFIG_LOADER_READBACK_EN : adds rb_data / rb_valid. The chain tail
//       (prog_out_last) is sampled every SHIFT_LO cycle, so the previous
//       configuration is returned word by word in the order it was written;
//       a final partial word is emitted in COMMIT with zero-padded LSBs.
//       Without it prog_out_last is ignored.
//
// Ports
//   clk, rst      : system clock, synchronous active-high reset
//   start         : one-cycle load request, ignored while busy
//   in_data       : bitstream word, MSB shifted first
//   in_valid      : in_data valid
//   in_ready      : word accepted this cycle (decoded from state)
//   prog_in       : serial data to the first element
//   prog_clk      : programming shift clock, elements shift on its rise
//   prog_en       : programming enable, falling edge commits
//   prog_out_last : serial output of the last element
//   busy          : load in progress
//   done          : one-cycle pulse after the commit
//   rb_data       : readback word          (readback build only)
//   rb_valid      : rb_data valid pulse    (readback build only)
// ============================================================================
module config_loader
    import fabric_cfg_pkg::*;
#(
    parameter int NUM_ELEMENTS = 4,
    parameter int LE_CFG_BITS  = fabric_cfg_pkg::LE_CFG_BITS,
    parameter int WORD_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              prog_in,
    output logic              prog_clk,
    output logic              prog_en,
    input  logic              prog_out_last,
    output logic              busy,
    output logic              done
`ifdef CONFIG_LOADER_READBACK_EN
    ,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
`endif
);

    localparam int TOTAL_BITS = NUM_ELEMENTS * LE_CFG_BITS;
    localparam int CNT_W      = $clog2(TOTAL_BITS + 1);
    localparam int SER_CNT_W  = $clog2(WORD_W + 1);

    loader_state_t    state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             prog_in_q;
    logic             prog_clk_q;
    logic             prog_en_q;
    logic             busy_q;
    logic             done_q;

    // ------------------------------------------------------------------
    // Outgoing word serializer
    // ------------------------------------------------------------------
    logic                 tx_load;
    logic                 tx_shift;
    logic                 tx_next_msb;
    logic                 tx_last;
    logic [WORD_W-1:0]    tx_word_unused;
    logic [SER_CNT_W-1:0] tx_cnt_unused;

    assign tx_load  = (state_q == ST_FETCH) && in_valid;
    assign tx_shift = (state_q == ST_SHIFT_HI);

    cfg_word_serializer #(
        .WORD_W (WORD_W)
    ) u_tx_ser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tx_load),
        .data_i     (in_data),
        .shift_i    (tx_shift),
        .serial_i   (1'b0),
        .word_o     (tx_word_unused),
        .next_msb_o (tx_next_msb),
        .count_o    (tx_cnt_unused),
        .last_o     (tx_last)
    );

    // ------------------------------------------------------------------
    // Sequencer. Outputs are set on the transition into a state so that
    // each registered output reflects the state it belongs to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            prog_in_q  <= 1'b0;
            prog_clk_q <= 1'b0;
            prog_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        prog_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Present the first bit now so it is stable for the
                    // whole SHIFT_LO cycle ahead of the prog_clk rise.
                    if (in_valid) begin
                        prog_in_q <= in_data[WORD_W-1];
                        state_q   <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    prog_clk_q <= 1'b1;
                    state_q    <= ST_SHIFT_HI;
                end
                ST_SHIFT_HI: begin
                    prog_clk_q <= 1'b0;
                    bit_cnt_q  <= bit_cnt_q + 1'b1;
                    // The total-bit test comes first so the unused LSBs of
                    // the final word are never shifted out.
                    if (bit_cnt_q == CNT_W'(TOTAL_BITS - 1)) begin
                        prog_en_q <= 1'b0;
                        prog_in_q <= 1'b0;
                        state_q   <= ST_COMMIT;
                    end else if (tx_last) begin
                        state_q   <= ST_FETCH;
                    end else begin
                        prog_in_q <= tx_next_msb;
                        state_q   <= ST_SHIFT_LO;
                    end
                end
                ST_COMMIT: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state_q == ST_FETCH);
    assign prog_in  = prog_in_q;
    assign prog_clk = prog_clk_q;
    assign prog_en  = prog_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef CONFIG_LOADER_READBACK_EN
    // ------------------------------------------------------------------
    // Readback: the chain tail holds the bit about to be pushed out by
    // the coming prog_clk rise, so it is sampled during SHIFT_LO.
    // ------------------------------------------------------------------
    logic                 rx_load;
    logic                 rx_shift;
    logic                 rx_last;
    logic                 rx_next_msb_unused;
    logic [WORD_W-1:0]    rx_word;
    logic [SER_CNT_W-1:0] rx_cnt;
    logic [WORD_W-1:0]    rb_data_q;
    logic                 rb_valid_q;

    assign rx_shift = (state_q == ST_SHIFT_LO);
    // Clear at load start, after each complete word, and after the flush.
    assign rx_load  = ((state_q == ST_IDLE) && start)
                    || (rx_shift && rx_last)
                    || (state_q == ST_COMMIT);

    cfg_word_serializer #(
        .WORD_W (WORD_W)
    ) u_rx_ser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rx_load),
        .data_i     ('0),
        .shift_i    (rx_shift),
        .serial_i   (prog_out_last),
        .word_o     (rx_word),
        .next_msb_o (rx_next_msb_unused),
        .count_o    (rx_cnt),
        .last_o     (rx_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;
            if (rx_shift && rx_last) begin
                rb_data_q  <= {rx_word[WORD_W-2:0], prog_out_last};
                rb_valid_q <= 1'b1;
            end else if ((state_q == ST_COMMIT) && (rx_cnt != '0)) begin
                // Left-align the partial word; zeros fill the LSBs.
                rb_data_q  <= rx_word << (SER_CNT_W'(WORD_W) - rx_cnt);
                rb_valid_q <= 1'b1;
            end
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`else
    logic prog_out_last_unused;
    assign prog_out_last_unused = prog_out_last;
`endif

endmodule : config_loader
`default_nettype wire

// File: tb/tb_config_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_config_loader
// Description : Self-checking bench for config_loader with a behavioural
//               4-element chain. Expected serial bits are queued as each
//               word is offered and compared against the bits seen at each
//               prog_clk rise; committed element contents, latency, done
//               count and (readback build) rb_data words are also checked.
//               Latency is counted inclusive of the start cycle and the
//               done cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_config_loader;
    import fabric_cfg_pkg::*;

    localparam int NUM_ELEMENTS = 4;
    localparam int LE_BITS      = fabric_cfg_pkg::LE_CFG_BITS;
    localparam int WORD_W       = 8;
    localparam int TOTAL_BITS   = NUM_ELEMENTS * LE_BITS;
    localparam int NUM_WORDS    = (TOTAL_BITS + WORD_W - 1) / WORD_W;
    localparam int PAD_BITS     = NUM_WORDS * WORD_W - TOTAL_BITS;
    localparam int MIN_LAT      = 2 * TOTAL_BITS + NUM_WORDS + 3;

    typedef logic [TOTAL_BITS-1:0] cfg_t;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              start    = 1'b0;
    logic [WORD_W-1:0] in_data  = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              prog_in;
    logic              prog_clk;
    logic              prog_en;
    logic              prog_out_last;
    logic              busy;
    logic              done;
`ifdef CONFIG_LOADER_READBACK_EN
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    config_loader #(
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .LE_CFG_BITS  (LE_BITS),
        .WORD_W       (WORD_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .prog_in       (prog_in),
        .prog_clk      (prog_clk),
        .prog_en       (prog_en),
        .prog_out_last (prog_out_last),
        .busy          (busy),
        .done          (done)
`ifdef CONFIG_LOADER_READBACK_EN
        ,
        .rb_data       (rb_data),
        .rb_valid      (rb_valid)
`endif
    );

    // ---------------- cycle counter and event monitors ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_cnt = 0;
    int done_cyc = 0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    logic [WORD_W-1:0] obs_rb[$];
`ifdef CONFIG_LOADER_READBACK_EN
    always @(negedge clk) if (rb_valid === 1'b1) obs_rb.push_back(rb_data);
`endif

    // ---------------- behavioural element chain ----------------
    logic [LE_BITS-1:0] sh  [NUM_ELEMENTS] = '{default: '0};
    logic [LE_BITS-1:0] act [NUM_ELEMENTS] = '{default: '0};
    int   rise_cnt = 0;
    logic exp_bits[$];
    logic obs_bits[$];

    assign prog_out_last = sh[NUM_ELEMENTS-1][LE_BITS-1];

    always @(posedge prog_clk) begin
        rise_cnt = rise_cnt + 1;
        obs_bits.push_back(prog_in);
        sh[0] <= {sh[0][LE_BITS-2:0], prog_in};
        for (int i = 1; i < NUM_ELEMENTS; i++)
            sh[i] <= {sh[i][LE_BITS-2:0], sh[i-1][LE_BITS-1]};
    end

    always @(negedge prog_en) begin
        for (int i = 0; i < NUM_ELEMENTS; i++) act[i] <= sh[i];
    end

    // ---------------- helpers ----------------
    function automatic logic [WORD_W-1:0] word_of(input cfg_t cfg, input int w);
        logic [NUM_WORDS*WORD_W-1:0] padded;
        logic [PAD_BITS-1:0]         junk;
        junk   = PAD_BITS'(11);   // nonzero filler that must be discarded
        padded = {cfg, junk};
        return padded[NUM_WORDS*WORD_W-1 - w*WORD_W -: WORD_W];
    endfunction

    task automatic push_expected(input cfg_t cfg, input int w);
        for (int b = 0; b < WORD_W; b++) begin
            int idx;
            idx = TOTAL_BITS - 1 - w * WORD_W - b;
            if (idx >= 0) exp_bits.push_back(cfg[idx]);
        end
    endtask

    task automatic send_words(input cfg_t cfg, input int first, input int last,
                              input int stall_idx, input int stall_cycles);
        for (int w = first; w <= last; w++) begin
            int n;
            n = 0;
            while (in_ready !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (in_ready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL fetch_timeout: word %0d in_ready=%b required 1", w, in_ready);
                return;
            end
            if (w == stall_idx) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    checks++;
                    if (prog_en !== 1'b1 || prog_clk !== 1'b0 || in_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL stall cycle %0d: prog_en=%b prog_clk=%b in_ready=%b required 1 0 1",
                                 s, prog_en, prog_clk, in_ready);
                    end
                    @(negedge clk);
                end
            end
            in_data  = word_of(cfg, w);
            in_valid = 1'b1;
            push_expected(cfg, w);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic check_bits(input string name);
        while (obs_bits.size() > 0) begin
            logic o;
            logic e;
            o = obs_bits.pop_front();
            checks++;
            if (exp_bits.size() == 0) begin
                errors++;
                $display("FAIL %s: extra prog_clk rise with prog_in=%b, no bit expected", name, o);
            end else begin
                e = exp_bits.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s: prog_in=%b expected %b (%0d bits left)", name, o, e, exp_bits.size());
                end
            end
        end
        checks++;
        if (exp_bits.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected bits never shifted, required 0", name, exp_bits.size());
        end
    endtask

    task automatic check_chain(input string name, input cfg_t cfg);
        for (int e = 0; e < NUM_ELEMENTS; e++) begin
            checks++;
            if (act[e] !== cfg[e*LE_BITS +: LE_BITS]) begin
                errors++;
                $display("FAIL %s: element %0d holds %h required %h", name, e, act[e], cfg[e*LE_BITS +: LE_BITS]);
            end
        end
    endtask

    task automatic run_load(input cfg_t cfg, input int stall_idx, input int stall_cycles,
                            input int restart_at, output int lat, output int dones);
        int d0;
        int s;
        int n;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (prog_en !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_response: prog_en=%b busy=%b in_ready=%b required 1 1 1", prog_en, busy, in_ready);
        end
        fork
            send_words(cfg, 0, NUM_WORDS - 1, stall_idx, stall_cycles);
            begin
                if (restart_at > 0) begin
                    repeat (restart_at - 1) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL done_timeout: done count %0d required %0d", done_cnt, d0 + 1);
            lat = -1;
        end else begin
            lat = done_cyc - s + 1;
            if (busy !== 1'b0 || prog_en !== 1'b0) begin
                errors++;
                $display("FAIL done_state: busy=%b prog_en=%b required 0 0", busy, prog_en);
            end
        end
        repeat (10) @(negedge clk);
        dones = done_cnt - d0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [5:0] got;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        got = {in_ready, busy, done, prog_en, prog_clk, prog_in};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_value bit %0d of {in_ready,busy,done,prog_en,prog_clk,prog_in}: %b required 0", i, got[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_load(input string name, input cfg_t cfg);
        int lat;
        int dones;
        run_load(cfg, -1, 0, 0, lat, dones);
        check_bits(name);
        check_chain(name, cfg);
        checks++;
        if (lat != MIN_LAT) begin
            errors++;
            $display("FAIL %s latency: %0d cycles required %0d", name, lat, MIN_LAT);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL %s done pulses: %0d required 1", name, dones);
        end
    endtask

    task automatic test_stall();
        cfg_t cfg;
        logic [95:0] r;
        int lat;
        int dones;
        r   = {$urandom(), $urandom(), $urandom()};
        cfg = r[TOTAL_BITS-1:0];
        run_load(cfg, 3, 20, 0, lat, dones);
        check_bits("stall");
        check_chain("stall", cfg);
        checks++;
        if (lat != MIN_LAT + 20) begin
            errors++;
            $display("FAIL stall latency: %0d cycles required %0d", lat, MIN_LAT + 20);
        end
    endtask

    task automatic test_lut();
        cfg_t cfg;
        cfg = {19'h7FFFF, 19'h12345, 19'h55555, {3'b000, 16'h8000}};
        test_full_load("lut_load", cfg);
        checks++;
        if (act[0][CFG_OUT_MUX_BIT:CFG_FF_EN_BIT] !== 3'b000) begin
            errors++;
            $display("FAIL lut_mux_bits: %b required 000", act[0][CFG_OUT_MUX_BIT:CFG_FF_EN_BIT]);
        end
        for (int a = 0; a < 16; a++) begin
            logic lut_out;
            logic [15:0] lut;
            lut     = act[0][CFG_LUT_MSB:CFG_LUT_LSB];
            lut_out = lut[a];
            checks++;
            if (lut_out !== (a == 15)) begin
                errors++;
                $display("FAIL lut_out in=%h: out=%b required %b", a[3:0], lut_out, (a == 15));
            end
        end
    endtask

    task automatic test_reset_midload();
        cfg_t cfg;
        int r0;
        int n;
        cfg = 76'h3_1415_9265_3589_7932;
        r0  = rise_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_words(cfg, 0, 3, -1, 0);
        n = 0;
        while (rise_cnt - r0 < 30 && n < 200) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (prog_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || prog_clk !== 1'b0) begin
            errors++;
            $display("FAIL midload_reset: prog_en=%b busy=%b done=%b in_ready=%b prog_clk=%b required all 0",
                     prog_en, busy, done, in_ready, prog_clk);
        end
        checks++;
        if (obs_bits.size() != 30) begin
            errors++;
            $display("FAIL midload_bits: %0d bits shifted before reset required 30", obs_bits.size());
        end
        rst = 1'b0;
        obs_bits.delete();
        exp_bits.delete();
        @(negedge clk);
        test_full_load("reload_after_reset", ~cfg);
    endtask

    task automatic test_back_to_back();
        cfg_t cfg;
        int lat;
        int dones;
        cfg = 76'hC_0FFE_E15B_AD00_D1E5;
        run_load(cfg, -1, 0, 50, lat, dones);
        check_bits("restart_ignored");
        check_chain("restart_ignored", cfg);
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL restart done pulses: %0d required 1", dones);
        end
        checks++;
        if (lat != MIN_LAT) begin
            errors++;
            $display("FAIL restart latency: %0d cycles required %0d", lat, MIN_LAT);
        end
    endtask

`ifdef CONFIG_LOADER_READBACK_EN
    task automatic test_readback();
        cfg_t a;
        cfg_t b;
        int lat;
        int dones;
        logic [WORD_W-1:0] exp_rb[$];
        logic [NUM_WORDS*WORD_W-1:0] padded;
        a = 76'h9_8765_4321_0FED_CBA5;
        b = 76'h1_2345_6789_ABCD_EF0A;
        test_full_load("readback_load_a", a);
        obs_rb.delete();
        padded = {a, {PAD_BITS{1'b0}}};
        for (int w = 0; w < NUM_WORDS; w++)
            exp_rb.push_back(padded[NUM_WORDS*WORD_W-1 - w*WORD_W -: WORD_W]);
        run_load(b, -1, 0, 0, lat, dones);
        check_bits("readback_load_b");
        check_chain("readback_load_b", b);
        checks++;
        if (obs_rb.size() != NUM_WORDS) begin
            errors++;
            $display("FAIL readback count: %0d words required %0d", obs_rb.size(), NUM_WORDS);
        end
        while (obs_rb.size() > 0 && exp_rb.size() > 0) begin
            logic [WORD_W-1:0] o;
            logic [WORD_W-1:0] e;
            o = obs_rb.pop_front();
            e = exp_rb.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL readback word: rb_data=%h expected %h (%0d left)", o, e, exp_rb.size());
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load("known_pattern", 76'hA5C3_F012_3456_789A_BCD);
        test_stall();
        test_lut();
        test_reset_midload();
        test_back_to_back();
`ifdef CONFIG_LOADER_READBACK_EN
        test_readback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_config_loader
`default_nettype wire
